// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Combinational sum/carry cell: a full adder built from two half adders.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0, c0, c1;

    half_adder u_ha0 (.x(a),  .y(b),   .s(s0), .c(c0));
    half_adder u_ha1 (.x(s0), .y(cin), .s(s),  .c(c1));

    // At most one half adder can produce a carry, so OR is enough.
    assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first, one bit per clock through a single
// full adder with the carry held in a flip-flop between bits.
// Optional: define SERIAL_ADDER_SUB_EN to add a 'sub' port (a - b in two's
// complement; carry_out=1 means no borrow).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_sh, b_sh, s_sh, s_next;
    logic               carry;
    logic [CNT_W-1:0]   count;
    logic               last;
    logic               fa_s, fa_c;

    full_adder u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .s   (fa_s),
        .cout(fa_c)
    );

    assign s_next = {fa_s, s_sh[WIDTH-1:1]};
    assign last   = (count == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, serial shifting and result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            s_sh      <= '0;
            carry     <= 1'b0;
            count     <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
`ifdef SERIAL_ADDER_SUB_EN
                        // a - b = a + ~b + 1: invert b, seed the carry.
                        b_sh  <= sub ? ~b : b;
                        carry <= sub;
`else
                        b_sh  <= b;
                        carry <= 1'b0;
`endif
                        count <= '0;
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_next;
                    carry <= fa_c;
                    count <= count + CNT_W'(1);
                    // Result registers only move on completion.
                    if (last) begin
                        sum       <= s_next;
                        carry_out <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
